hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It generates per-stage stall and flush controls from four sources: load-use hazards, ID-stage branch operand hazards, data-memory wait and trap redirects. It complements the forwarding logic: it stalls exactly in the cases forwarding cannot cover, which are load results in EXE_MEM and any producer still in ID_EXE for a branch in ID. It also tracks a pending trap and keeps stall/flush performance counters.

Parameters:
CNT_WIDTH, 32, width of the performance counters
MEM_TIMEOUT, 255, number of consecutive mem_busy cycles after which mem_timeout is set

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_addr  in  `GPR_ADDR_SPACE  ID source 1 address
id_rs1_re  in  1  ID reads rs1
id_rs2_addr  in  `GPR_ADDR_SPACE  ID source 2 address
id_rs2_re  in  1  ID reads rs2
id_is_branch  in  1  ID holds a branch/jalr resolved in ID
branch_taken  in  1  ID branch unit redirects the PC
id_exe_rd_addr  in  `GPR_ADDR_SPACE  ID_EXE destination
id_exe_rd_we  in  1  ID_EXE writes rd
id_exe_mem_re  in  1  ID_EXE is a load
exe_mem_rd_addr  in  `GPR_ADDR_SPACE  EXE_MEM destination
exe_mem_rd_we  in  1  EXE_MEM writes rd
exe_mem_mem_re  in  1  EXE_MEM is a load
mem_busy  in  1  data memory not ready
trap_req  in  1  single-cycle trap pulse from MEM
pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall  out  1 each  hold the register
if_id_flush, id_exe_flush, exe_mem_flush  out  1 each  load a bubble
state  out  2  RUN=0, STALL=1, MEM_WAIT=2, FLUSH=3
stall_cnt  out  CNT_WIDTH  cycles with pc_stall high
flush_cnt  out  CNT_WIDTH  cycles with any flush high
mem_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: state=RUN, trap_pend=0, counters=0, mem_timeout=0, internal wait counter=0. All stall and flush outputs are 0 while rst is high.
- State is registered. All stall and flush outputs are combinational from the current inputs, state and trap_pend, so they take effect in the same cycle.
- Operand match (for rs1 and for rs2, independently): addr!=0 && re && addr==producer_rd && producer_we.
- lu_haz: operand match against ID_EXE && id_exe_mem_re.
- br_haz: id_is_branch && (operand match against ID_EXE of any kind, or operand match against EXE_MEM with exe_mem_mem_re).
- Priority, highest first:
  1. mem_busy: every *_stall=1, every flush=0. Next state=MEM_WAIT. A trap_req seen in this cycle sets trap_pend.
  2. trap_req || trap_pend: if_id_flush, id_exe_flush and exe_mem_flush all 1; all stalls 0. Clear trap_pend. Next state=FLUSH.
  3. state==FLUSH (redirect shadow): if_id_flush=1 only. Next state=RUN, unless a rule above applies.
  4. lu_haz || br_haz: pc_stall=1, if_id_stall=1, id_exe_flush=1 (bubble). branch_taken is ignored. Next state=STALL.
  5. branch_taken: if_id_flush=1. Next state=RUN.
  6. Otherwise all outputs 0. Next state=RUN.
- Required stall lengths: load→use needs 1 bubble. ALU producer→branch needs 1 bubble. Load→branch needs 2 bubbles (one for ID_EXE, one for EXE_MEM).
- MEM_WAIT:
  - The wait counter increments each mem_busy cycle, saturating at MEM_TIMEOUT.
  - mem_timeout is set when the counter reaches MEM_TIMEOUT and stays set until rst.
  - The counter clears on the first cycle mem_busy is low.
- Counters: stall_cnt and flush_cnt increment by 1 per qualifying cycle and wrap modulo 2^CNT_WIDTH.
- Reset mid-stall or mid-trap drops trap_pend and returns to RUN. No flush is issued in the reset cycle.

Test Plan:
- Load-use: ID_EXE has a load writing x5, ID reads x5 → exactly 1 cycle with pc_stall=1, if_id_stall=1, id_exe_flush=1, then RUN; stall_cnt=1.
- Load→branch: load writing x7, then beq on x7 in ID → stall 2 consecutive cycles (ID_EXE match, then EXE_MEM load match); stall_cnt=2.
- x0 and disabled reads: producer rd=0 matching, or re=0 → no stall.
- mem_busy held 3 cycles with trap_req pulsed in cycle 2 → 3 cycles with all stalls high and no flush; then 1 cycle with all three flushes, then 1 FLUSH cycle with if_id_flush only.
- branch_taken concurrent with lu_haz → stall only, if_id_flush=0; branch_taken the next cycle with no hazard → if_id_flush=1, flush_cnt=1.
- MEM_TIMEOUT=4 with mem_busy held 6 cycles → mem_timeout rises when the wait counter reaches 4 and stays high after mem_busy drops; rst clears it and all counters.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the 5-stage core.
//
// Purpose:
//   Produces per-stage stall and flush controls for the pipeline. It stalls only
//   where forwarding cannot help: a load result still in EXE_MEM, or any result
//   in ID_EXE that a branch resolved in ID needs. It also handles data-memory
//   wait and trap redirects, remembers a trap that arrives during a memory wait,
//   and counts stall and flush cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1_*/id_rs2_*        ID-stage source operand addresses and read enables
//   id_is_branch             ID holds a branch/jalr resolved in ID
//   branch_taken             ID branch unit redirects the PC
//   id_exe_rd_*/id_exe_mem_re    destination, write enable and load flag in ID_EXE
//   exe_mem_rd_*/exe_mem_mem_re  destination, write enable and load flag in EXE_MEM
//   mem_busy                 data memory not ready
//   trap_req                 single-cycle trap pulse from MEM
//   *_stall                  hold the stage register (combinational)
//   *_flush                  load a bubble into the stage register (combinational)
//   state                    RUN=0, STALL=1, MEM_WAIT=2, FLUSH=3
//   stall_cnt / flush_cnt    cycles with pc_stall high / with any flush high
//   mem_timeout              sticky: mem_busy lasted MEM_TIMEOUT cycles in a row
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module hazard_ctrl #(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`GPR_ADDR_SPACE] id_rs1_addr,
   input  logic                   id_rs1_re,
   input  logic [`GPR_ADDR_SPACE] id_rs2_addr,
   input  logic                   id_rs2_re,
   input  logic                   id_is_branch,
   input  logic                   branch_taken,
   input  logic [`GPR_ADDR_SPACE] id_exe_rd_addr,
   input  logic                   id_exe_rd_we,
   input  logic                   id_exe_mem_re,
   input  logic [`GPR_ADDR_SPACE] exe_mem_rd_addr,
   input  logic                   exe_mem_rd_we,
   input  logic                   exe_mem_mem_re,
   input  logic                   mem_busy,
   input  logic                   trap_req,
   output logic                   pc_stall,
   output logic                   if_id_stall,
   output logic                   id_exe_stall,
   output logic                   exe_mem_stall,
   output logic                   mem_wb_stall,
   output logic                   if_id_flush,
   output logic                   id_exe_flush,
   output logic                   exe_mem_flush,
   output logic [1:0]             state,
   output logic [CNT_WIDTH-1:0]   stall_cnt,
   output logic [CNT_WIDTH-1:0]   flush_cnt,
   output logic                   mem_timeout
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_STALL    = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;
   localparam logic [1:0] ST_FLUSH    = 2'd3;

   localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   logic [1:0]           state_q, state_d;
   logic                 trap_pend_q, trap_pend_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 mem_timeout_q, mem_timeout_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

   // Operand match per source register: index 0 = rs1, index 1 = rs2.
   logic [`GPR_ADDR_SPACE] src_addr [2];
   logic [1:0]             src_re;
   logic [1:0]             ie_match;
   logic [1:0]             em_match;

   assign src_addr[0] = id_rs1_addr;
   assign src_addr[1] = id_rs2_addr;
   assign src_re      = {id_rs2_re, id_rs1_re};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_match
         // x0 is hard-wired zero, so a "write" to it never creates a dependency.
         assign ie_match[gi] = (src_addr[gi] != '0) && src_re[gi] &&
                               (src_addr[gi] == id_exe_rd_addr) && id_exe_rd_we;
         assign em_match[gi] = (src_addr[gi] != '0) && src_re[gi] &&
                               (src_addr[gi] == exe_mem_rd_addr) && exe_mem_rd_we;
      end
   endgenerate

   logic lu_haz, br_haz;
   // A branch in ID cannot get anything forwarded from ID_EXE, and a load in
   // EXE_MEM has no data yet; ALU results in EXE_MEM forward normally.
   assign lu_haz = (|ie_match) && id_exe_mem_re;
   assign br_haz = id_is_branch && ((|ie_match) || ((|em_match) && exe_mem_mem_re));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         trap_pend_q   <= 1'b0;
         wait_q        <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         trap_pend_q   <= trap_pend_d;
         wait_q        <= wait_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_q + CNT_WIDTH'(pc_stall);
         flush_cnt_q   <= flush_cnt_q + CNT_WIDTH'(if_id_flush | id_exe_flush | exe_mem_flush);
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = ST_RUN;
      trap_pend_d = trap_pend_q;
      if (mem_busy) begin
         state_d = ST_MEM_WAIT;
         // The redirect cannot happen while memory holds the pipe; keep it for later.
         if (trap_req) trap_pend_d = 1'b1;
      end else if (trap_req || trap_pend_q) begin
         state_d     = ST_FLUSH;
         trap_pend_d = 1'b0;
      end else if (state_q == ST_FLUSH) begin
         state_d = ST_RUN;
      end else if (lu_haz || br_haz) begin
         state_d = ST_STALL;
      end

      if (!mem_busy)            wait_d = '0;
      else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
      else                      wait_d = wait_q;
      mem_timeout_d = mem_timeout_q || (wait_d == WAIT_MAX);
   end

   // Output logic: same-cycle controls from inputs, state and pending trap.
   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      id_exe_stall  = 1'b0;
      exe_mem_stall = 1'b0;
      mem_wb_stall  = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_flush  = 1'b0;
      exe_mem_flush = 1'b0;
      if (rst) begin
         // everything stays low during reset
      end else if (mem_busy) begin
         pc_stall      = 1'b1;
         if_id_stall   = 1'b1;
         id_exe_stall  = 1'b1;
         exe_mem_stall = 1'b1;
         mem_wb_stall  = 1'b1;
      end else if (trap_req || trap_pend_q) begin
         if_id_flush   = 1'b1;
         id_exe_flush  = 1'b1;
         exe_mem_flush = 1'b1;
      end else if (state_q == ST_FLUSH) begin
         // Redirect shadow: the instruction fetched during the trap cycle is wrong-path.
         if_id_flush = 1'b1;
      end else if (lu_haz || br_haz) begin
         // Hold IF/ID and insert a bubble; a taken branch waits for its operands.
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_exe_flush = 1'b1;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
      end
   end

   assign state       = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a spec-level reference model.
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module tb_hazard_ctrl;

   localparam int TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   logic [`GPR_ADDR_SPACE] rs1, rs2, ie_rd, em_rd;
   logic                   re1, re2, br, taken, ie_we, ie_mre, em_we, em_mre, busy, trap;
   logic pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall;
   logic if_id_flush, id_exe_flush, exe_mem_flush, mem_timeout;
   logic [1:0]  state;
   logic [31:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.CNT_WIDTH(32), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(rs1), .id_rs1_re(re1), .id_rs2_addr(rs2), .id_rs2_re(re2),
      .id_is_branch(br), .branch_taken(taken),
      .id_exe_rd_addr(ie_rd), .id_exe_rd_we(ie_we), .id_exe_mem_re(ie_mre),
      .exe_mem_rd_addr(em_rd), .exe_mem_rd_we(em_we), .exe_mem_mem_re(em_mre),
      .mem_busy(busy), .trap_req(trap),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_exe_stall(id_exe_stall),
      .exe_mem_stall(exe_mem_stall), .mem_wb_stall(mem_wb_stall),
      .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .exe_mem_flush(exe_mem_flush),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   // Model state
   int          m_state;
   bit          m_pend, m_to;
   int          m_wait;
   int unsigned m_stall, m_flush;

   // Optional hand-computed expectation for the control vector of the next tick:
   // {pc, if_id, id_exe, exe_mem, mem_wb stalls, if_id, id_exe, exe_mem flushes}
   bit       lit_en;
   bit [7:0] lit_val;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit dep(input logic [4:0] a, input logic re, input logic [4:0] rd, input logic we);
      return (a != 0) && re && (a == rd) && we;
   endfunction

   task automatic idle();
      rst = 0; rs1 = 0; rs2 = 0; re1 = 0; re2 = 0; br = 0; taken = 0;
      ie_rd = 0; ie_we = 0; ie_mre = 0; em_rd = 0; em_we = 0; em_mre = 0;
      busy = 0; trap = 0;
   endtask

   // Inputs are driven just after a falling edge; outputs are checked 1 ns later,
   // then the model advances for the coming rising edge.
   task automatic tick(input string tag);
      bit [7:0] e, a;
      bit ie_dep, em_dep, haz;
      #1;
      ie_dep = dep(rs1, re1, ie_rd, ie_we) || dep(rs2, re2, ie_rd, ie_we);
      em_dep = dep(rs1, re1, em_rd, em_we) || dep(rs2, re2, em_rd, em_we);
      haz    = (ie_dep && ie_mre) || (br && (ie_dep || (em_dep && em_mre)));
      if (rst)                   e = 8'b00000_000;
      else if (busy)             e = 8'b11111_000;
      else if (trap || m_pend)   e = 8'b00000_111;
      else if (m_state == 3)     e = 8'b00000_100;
      else if (haz)              e = 8'b11000_010;
      else if (taken)            e = 8'b00000_100;
      else                       e = 8'b00000_000;
      a = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall,
           if_id_flush, id_exe_flush, exe_mem_flush};
      chk({tag, ".ctl"}, a, e);
      chk({tag, ".state"}, state, m_state);
      chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
      chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
      chk({tag, ".timeout"}, mem_timeout, m_to);
      if (lit_en) chk({tag, ".lit"}, a, lit_val);
      lit_en = 0;
      $display("tick %-10s rst=%0b busy=%0b trap=%0b ctl=%b state=%0d stall=%0d flush=%0d to=%0b",
               tag, rst, busy, trap, a, state, stall_cnt, flush_cnt, mem_timeout);
      // advance model
      if (rst) begin
         m_state = 0; m_pend = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else begin
         m_stall += e[7];
         m_flush += (|e[2:0]);
         m_wait = busy ? ((m_wait < TO) ? m_wait + 1 : TO) : 0;
         if (m_wait == TO) m_to = 1;
         if (busy) begin
            m_state = 2;
            if (trap) m_pend = 1;
         end else if (trap || m_pend) begin
            m_state = 3; m_pend = 0;
         end else if (m_state == 3) m_state = 0;
         else if (haz) m_state = 1;
         else m_state = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_ctl(input bit [7:0] v);
      lit_en = 1; lit_val = v;
   endtask

   task automatic do_reset();
      idle(); rst = 1; expect_ctl(8'h00); tick("reset"); idle();
   endtask

   initial begin
      lit_en = 0; lit_val = 0;
      m_state = 0; m_pend = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      idle(); rst = 1;
      @(negedge clk);
      do_reset();
      chk("rst.state", state, 0);
      chk("rst.cnt", stall_cnt | flush_cnt, 0);

      // Load-use: load x5 in ID_EXE, ID reads x5
      ie_rd = 5; ie_we = 1; ie_mre = 1; rs1 = 5; re1 = 1;
      expect_ctl(8'b11000_010); tick("lu");
      idle(); expect_ctl(8'h00); tick("lu.after");
      chk("lu.stall_cnt", stall_cnt, 1);
      chk("lu.state", state, 0);

      // Load -> branch: two bubbles
      do_reset();
      ie_rd = 7; ie_we = 1; ie_mre = 1; br = 1; rs2 = 7; re2 = 1;
      expect_ctl(8'b11000_010); tick("lb.1");
      idle(); br = 1; rs2 = 7; re2 = 1; em_rd = 7; em_we = 1; em_mre = 1;
      expect_ctl(8'b11000_010); tick("lb.2");
      idle(); br = 1; rs2 = 7; re2 = 1;
      expect_ctl(8'h00); tick("lb.3");
      chk("lb.stall_cnt", stall_cnt, 2);

      // ALU producer -> branch: one bubble; ALU in EXE_MEM forwards
      do_reset();
      ie_rd = 9; ie_we = 1; br = 1; rs1 = 9; re1 = 1;
      expect_ctl(8'b11000_010); tick("ab.1");
      idle(); br = 1; rs1 = 9; re1 = 1; em_rd = 9; em_we = 1;
      expect_ctl(8'h00); tick("ab.2");

      // x0 and disabled reads never stall
      idle(); ie_rd = 0; ie_we = 1; ie_mre = 1; rs1 = 0; re1 = 1; br = 1;
      expect_ctl(8'h00); tick("x0");
      idle(); ie_rd = 5; ie_we = 1; ie_mre = 1; rs1 = 5; re1 = 0; rs2 = 5; re2 = 0;
      expect_ctl(8'h00); tick("re0");
      idle(); em_rd = 3; em_we = 1; em_mre = 1; rs1 = 3; re1 = 1;
      expect_ctl(8'h00); tick("em.nobr");

      // mem_busy x3 with trap in cycle 2
      do_reset();
      busy = 1; expect_ctl(8'b11111_000); tick("mb.1");
      trap = 1; expect_ctl(8'b11111_000); tick("mb.2");
      trap = 0; expect_ctl(8'b11111_000); tick("mb.3");
      idle(); expect_ctl(8'b00000_111); tick("mb.trap");
      chk("mb.state", state, 3);
      expect_ctl(8'b00000_100); tick("mb.shadow");
      expect_ctl(8'h00); tick("mb.run");
      chk("mb.stall_cnt", stall_cnt, 3);
      chk("mb.flush_cnt", flush_cnt, 2);

      // branch_taken with lu_haz -> stall only; next cycle the redirect flushes
      do_reset();
      ie_rd = 4; ie_we = 1; ie_mre = 1; rs1 = 4; re1 = 1; taken = 1;
      expect_ctl(8'b11000_010); tick("bt.haz");
      idle(); taken = 1; expect_ctl(8'b00000_100); tick("bt.go");
      idle(); expect_ctl(8'h00); tick("bt.idle");
      chk("bt.stall_cnt", stall_cnt, 1);

      // Reset while a trap is pending drops it
      do_reset();
      busy = 1; trap = 1; tick("rp.busy");
      idle(); rst = 1; expect_ctl(8'h00); tick("rp.rst");
      idle(); expect_ctl(8'h00); tick("rp.after");

      // Timeout: mem_busy held 6 cycles with MEM_TIMEOUT=4
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         busy = 1; tick("to.busy");
         chk("to.flag", mem_timeout, (i >= TO) ? 1 : 0);
      end
      idle(); tick("to.drop");
      chk("to.sticky", mem_timeout, 1);
      do_reset();
      chk("to.cleared", mem_timeout, 0);
      chk("to.cnt_cleared", stall_cnt | flush_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
